sync_memory: RTL and testbench
==============================

SYNC_MEMORY -- requirements
Module: sync_memory

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1; when 1, the array is zero-swept after reset.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 read_en  input  1  read request, sampled at the rising edge.
REQ-008 write_en  input  1  write request, sampled at the rising edge.
REQ-009 address  input  ADDR_WIDTH  word address for read and write.
REQ-010 wr_data  input  DATA_WIDTH  write data.
REQ-011 clear  input  1  soft-clear request; starts a zero sweep when in IDLE.
REQ-012 rd_data  output  DATA_WIDTH  registered read data.
REQ-013 rd_valid  output  1  one-cycle pulse: rd_data carries a new read result.
REQ-014 busy  output  1  high while a sweep runs; requests are not accepted.

Function
REQ-015 The FSM SHALL have two states: IDLE and CLEAR.
REQ-016 In CLEAR, one word per cycle SHALL be written with zero, from address 0 up to DEPTH-1, using an internal counter of ADDR_WIDTH bits.
REQ-017 CLEAR SHALL last exactly DEPTH cycles, then go to IDLE with busy low on the next cycle.
REQ-018 busy SHALL be high exactly when the state is CLEAR.
REQ-019 In IDLE, an edge with clear=1 SHALL enter CLEAR with the counter at 0; write_en and read_en on that same edge SHALL be ignored.
REQ-020 While busy, read_en, write_en and clear SHALL be ignored; no array write occurs from wr_data and rd_valid stays 0.
REQ-021 In IDLE, write_en=1 SHALL store wr_data at address on that edge.
REQ-022 In IDLE, read_en=1 SHALL load mem[address] into rd_data on that edge and assert rd_valid for exactly the following cycle. Read latency is 1 cycle.
REQ-023 With read_en and write_en both high to the same address, the read SHALL return the old contents (read-before-write) and the write SHALL still occur.
REQ-024 Back-to-back reads SHALL be supported one per cycle, with rd_valid high continuously.
REQ-025 rd_data SHALL hold its last value when no read is accepted.
REQ-026 Locations never written and never swept (CLEAR_ON_RESET=0) SHALL read as X in simulation; no value is guaranteed.
REQ-027 The address space SHALL be fully decoded; there is no out-of-range address.

Reset
REQ-028 When rst_n is low, rd_data SHALL be 0, rd_valid SHALL be 0, and the counter SHALL be 0, asynchronously.
REQ-029 During reset, the state SHALL be CLEAR and busy SHALL be 1 if CLEAR_ON_RESET=1; otherwise the state SHALL be IDLE and busy SHALL be 0.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep; the sweep SHALL restart from address 0 after release.
REQ-031 The array contents SHALL NOT be reset directly; only the sweep clears them.

Structure
REQ-032 The state encodings (IDLE=0, CLEAR=1) and the default widths SHALL be defined in the shared definitions file memory_defs.
REQ-033 The storage SHALL be one sub-module, mem_array (single write port, synchronous read port, no reset).
REQ-034 The sweep writes SHALL be muxed onto the mem_array write port: address = counter, data = 0.

Verification
REQ-035 Defaults, CLEAR_ON_RESET=1, release rst_n -> busy=1 for exactly 32 cycles, then busy=0; a read of 5'b0_1001 then returns 8'h00.
REQ-036 Write 8'h35@10101, 8'hC1@10111, 8'hFF@11001, 8'hB4@10011, then read each -> rd_data equals the written value one cycle after its read, with a single rd_valid pulse per read.
REQ-037 10111 holds 8'hC1; apply read_en and write_en of 8'hA5 together at 10111 -> rd_data=8'hC1; the next read returns 8'hA5.
REQ-038 Pulse clear, then issue writes during busy -> all writes ignored; after 32 cycles, reads of 10101 and 11001 return 8'h00.
REQ-039 Assert rst_n low at sweep counter 12, release -> sweep restarts at 0, and busy lasts a full 32 cycles.
REQ-040 DATA_WIDTH=16, ADDR_WIDTH=3, CLEAR_ON_RESET=0 -> busy=0 right after reset; a write of 16'hBEEF at address 7 reads back 16'hBEEF.

Source files
------------

// File: rtl/memory_defs.sv
// Shared definitions for the sync_memory block: default geometry and the
// sweep FSM state encoding.
package memory_defs;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/mem_array.sv
// Single-write-port storage with a registered, enabled read port.
// Only the read register is reset; the array itself never is.
module mem_array #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Non-blocking read of the same edge as a write returns the old word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_memory.sv
// Synchronous single-port memory with a zero-sweep clear FSM that owns the
// write port while busy. dbg_state exposes the FSM state (0=IDLE, 1=CLEAR).
module sync_memory
    import memory_defs::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read_en,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  dbg_state
);

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_rd_valid;

    logic                  w_idle;
    logic                  w_accept;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;

    // A clear request in IDLE takes priority over any read/write on that edge.
    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = w_idle && !clear;
    assign w_rd_en  = w_accept && read_en;
    assign w_wr_en  = !w_idle || (w_accept && write_en);
    assign w_wr_addr = w_idle ? address : r_cnt;
    assign w_wr_data = w_idle ? wr_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RESET_STATE;
            r_cnt      <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rd_valid <= w_rd_en;
                    if (clear) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                    end
                end
                ST_CLEAR: begin
                    r_rd_valid <= 1'b0;
                    r_cnt      <= r_cnt + 1'b1;
                    if (&r_cnt) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_rd_valid <= 1'b0;
                end
            endcase
        end
    end

    mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem_array (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (address),
        .o_rd_data (rd_data)
    );

    assign rd_valid  = r_rd_valid;
    assign busy      = (r_state == ST_CLEAR);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sync_memory.sv
// Bench for sync_memory: default instance plus a 16x8 no-clear-on-reset instance.
module tb_sync_memory;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        read_en, write_en, clear;
    logic [4:0]  address;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        rd_valid, busy, dbg_state;

    logic        read_en2, write_en2, clear2;
    logic [2:0]  address2;
    logic [15:0] wr_data2;
    logic [15:0] rd_data2;
    logic        rd_valid2, busy2, dbg_state2;

    int checks = 0;
    int errors = 0;

    logic [7:0] model [32];
    logic [7:0] exp_q [$];
    logic [7:0] last_rd;

    typedef struct {
        logic       we;
        logic       re;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic       exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    sync_memory dut (
        .clk(clk), .rst_n(rst_n), .read_en(read_en), .write_en(write_en),
        .address(address), .wr_data(wr_data), .clear(clear),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .dbg_state(dbg_state)
    );

    sync_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .CLEAR_ON_RESET(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n), .read_en(read_en2), .write_en(write_en2),
        .address(address2), .wr_data(wr_data2), .clear(clear2),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .busy(busy2), .dbg_state(dbg_state2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        read_en = 1'b0; write_en = 1'b0; clear = 1'b0;
        address = '0; wr_data = '0;
    endtask

    task automatic count_busy(input string name);
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            cycle();
            n++;
        end
        check(name, n, 32);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [7:0] d);
        write_en = 1'b1; address = a; wr_data = d;
        cycle();
        write_en = 1'b0;
        model[a] = d;
    endtask

    task automatic do_read(input string name, input logic [4:0] a, input logic [7:0] exp);
        read_en = 1'b1; address = a;
        cycle();
        read_en = 1'b0;
        check({name, "_valid"}, rd_valid, 1);
        check({name, "_data"}, rd_data, exp);
        last_rd = exp;
        cycle();
        check({name, "_pulse_end"}, rd_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        read_en2 = 1'b0; write_en2 = 1'b0; clear2 = 1'b0;
        address2 = '0; wr_data2 = '0;

        // Reset values, then the power-up sweep.
        #12;
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_busy", busy, 1);
        check("rst_state", dbg_state, 1);
        check("rst_busy2", busy2, 0);
        check("rst_rd_data2", rd_data2, 0);
        rst_n = 1'b1;
        count_busy("sweep_len_reset");
        check("idle_state", dbg_state, 0);
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
        last_rd = 8'h00;

        // Vector table: back-to-back accesses, read-before-write, hold.
        vecs[0]  = '{0, 1, 5'b01001, 8'h00, 1, 8'h00};
        vecs[1]  = '{1, 0, 5'b10101, 8'h35, 0, 8'h00};
        vecs[2]  = '{1, 0, 5'b10111, 8'hC1, 0, 8'h00};
        vecs[3]  = '{1, 0, 5'b11001, 8'hFF, 0, 8'h00};
        vecs[4]  = '{1, 0, 5'b10011, 8'hB4, 0, 8'h00};
        vecs[5]  = '{0, 1, 5'b10101, 8'h00, 1, 8'h35};
        vecs[6]  = '{0, 1, 5'b10111, 8'h00, 1, 8'hC1};
        vecs[7]  = '{0, 1, 5'b11001, 8'h00, 1, 8'hFF};
        vecs[8]  = '{0, 1, 5'b10011, 8'h00, 1, 8'hB4};
        vecs[9]  = '{1, 1, 5'b10111, 8'hA5, 1, 8'hC1};
        vecs[10] = '{0, 1, 5'b10111, 8'h00, 1, 8'hA5};
        vecs[11] = '{0, 0, 5'b00000, 8'h00, 0, 8'hA5};
        for (int i = 0; i < 12; i++) begin
            write_en = vecs[i].we; read_en = vecs[i].re;
            address = vecs[i].addr; wr_data = vecs[i].wdata;
            cycle();
            check($sformatf("vec%0d_valid", i), rd_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid || i == 11)
                check($sformatf("vec%0d_data", i), rd_data, vecs[i].exp_data);
            if (vecs[i].we) model[vecs[i].addr] = vecs[i].wdata;
        end
        idle_inputs();
        last_rd = 8'hA5;

        // Random traffic against the array model.
        for (int i = 0; i < 300; i++) begin
            logic       re, we;
            logic [4:0] a;
            logic [7:0] d;
            re = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            a  = 5'($urandom_range(0, 31));
            d  = 8'($urandom);
            read_en = re; write_en = we; address = a; wr_data = d;
            if (re) exp_q.push_back(model[a]);
            if (we) model[a] = d;
            cycle();
            if (re) begin
                last_rd = exp_q.pop_front();
                check("rand_valid", rd_valid, 1);
                check("rand_data", rd_data, last_rd);
            end else begin
                check("rand_idle_valid", rd_valid, 0);
                check("rand_hold", rd_data, last_rd);
            end
        end
        idle_inputs();

        // Soft clear with traffic on the clear edge and throughout the sweep.
        do_write(5'b10101, 8'h35);
        do_write(5'b11001, 8'hFF);
        clear = 1'b1; write_en = 1'b1; read_en = 1'b1; address = 5'b10101; wr_data = 8'h77;
        cycle();
        clear = 1'b0;
        check("clear_busy", busy, 1);
        check("clear_edge_no_valid", rd_valid, 0);
        begin
            int n = 0;
            while (busy === 1'b1 && n < 100) begin
                write_en = 1'b1; read_en = 1'b1;
                address = 5'($urandom_range(0, 31)); wr_data = 8'($urandom_range(1, 255));
                cycle();
                n++;
                check("busy_no_valid", rd_valid, 0);
                check("busy_hold", rd_data, last_rd);
            end
            check("sweep_len_clear", n, 32);
        end
        idle_inputs();
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
        do_read("clr_rd_10101", 5'b10101, 8'h00);
        do_read("clr_rd_11001", 5'b11001, 8'h00);

        // Reset in the middle of a sweep restarts it from address 0.
        do_write(5'b00011, 8'h5A);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        repeat (12) cycle();
        rst_n = 1'b0;
        #2;
        check("midrst_busy", busy, 1);
        check("midrst_valid", rd_valid, 0);
        check("midrst_data", rd_data, 0);
        rst_n = 1'b1;
        count_busy("sweep_len_midrst");
        do_read("midrst_rd_00011", 5'b00011, 8'h00);
        do_read("midrst_rd_01001", 5'b01001, 8'h00);

        // Narrow instance without power-up sweep.
        check("w_busy", busy2, 0);
        write_en2 = 1'b1; address2 = 3'd7; wr_data2 = 16'hBEEF;
        cycle();
        write_en2 = 1'b0; read_en2 = 1'b1;
        cycle();
        read_en2 = 1'b0;
        check("w_valid", rd_valid2, 1);
        check("w_data", rd_data2, 16'hBEEF);
        cycle();
        check("w_pulse_end", rd_valid2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
